muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit for the MIPS pipeline, implementing MULT, MULTU, DIV and DIVU plus MTHI/MTLO writes into architectural HI/LO registers. It sits in the execute stage beside the ALU. Its `hi` and `lo` outputs feed two inputs of the writeback-select mux4 for MFHI/MFLO. `busy` drives the hazard unit so dependent instructions stall until the result is committed.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation `op` on `a`, `b`; accepted only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold a new result.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + `start`:
  - Latch |a| and |b|; signed ops use two's-complement magnitude, unsigned ops use the raw value.
  - Latch sign flags: quotient/product negative = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the iteration counter; go to CALC.
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Leave after `WIDTH` iterations (counter `WIDTH-1` → FIX).
- FIX: negate result parts as the sign flags require; write HI/LO; go to IDLE; `done` is set for the following cycle.
- Result mapping:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (DIV and DIVU): LO = all-ones, HI = `a` unmodified; sign fixing is skipped. The full iteration count still runs.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0. This falls out of the magnitude datapath; no special case.
- `start` while `busy`: ignored.
- `mthi`/`mtlo` in IDLE:
  - Update the register at the next edge.
  - Both asserted writes both registers.
  - If `start` is asserted in the same cycle, `start` wins and the writes are dropped.
- `mthi`/`mtlo` while `busy`: ignored. The hazard unit guarantees they never arrive in this state.
- `op`, `a`, `b` are sampled only at the accepting edge; later changes have no effect.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0; state IDLE; counter 0; internal datapath registers 0.
- `start` sampled at edge E0:
  - `busy`=1 from just after E0.
  - Iterations run at E1…E32 (WIDTH=32); FIX at E33.
  - After E33: HI/LO valid, `busy`=0, `done`=1 for exactly one cycle.
  - Latency from the start edge to a visible result is `WIDTH`+1 cycles.
- A new `start` in the `done` cycle is accepted, giving a back-to-back issue period of `WIDTH`+2 cycles.
- `hi`/`lo` change only at FIX or on an accepted MTHI/MTLO write. They hold their old values throughout CALC.
- `reset` mid-operation: immediate return to reset values; the aborted operation produces no `done`.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - state enum (IDLE, CALC, FIX);
  - `ITER_W` = clog2(WIDTH) for the counter width.
- One sub-module: `muldiv_signfix`. It is combinational and holds the magnitude/negate logic used on entry (abs) and at FIX (conditional negate of product, quotient and remainder).
- The FSM, counter, accumulator and HI/LO registers live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 → LO=3, HI=1.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start MULTU 2×3; pulse `start` with DIVU 9/3 at cycle 5; pulse `mthi` with 0xAA at cycle 6 → both ignored; result HI=0, LO=6; single `done`.
- IDLE `mthi`+`mtlo` with 0x1234 → HI=LO=0x1234 next cycle. Same-cycle `start` MULTU 2×2 with `mtlo` 0x55 → LO=4 after completion, never 0x55.
- Assert `reset` at cycle 10 of a DIV → HI=LO=0, `busy`=0, no `done` pulse. A new DIVU 10/3 after reset gives LO=3, HI=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, counter width.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int ITER_W   = $clog2(MD_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
endpackage

// File: rtl/muldiv_signfix.sv
// Magnitude extraction on entry and conditional negation of results on exit.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [WIDTH-1:0]   o_abs_a,
  output logic [WIDTH-1:0]   o_abs_b,
  input  logic [2*WIDTH-1:0] i_res,
  input  logic               i_is_div,
  input  logic               i_neg_main,
  input  logic               i_neg_rem,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign o_abs_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign o_abs_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  assign w_prod = i_neg_main ? -i_res : i_res;
  assign w_quo  = i_neg_main ? -i_res[WIDTH-1:0] : i_res[WIDTH-1:0];
  assign w_rem  = i_neg_rem  ? -i_res[2*WIDTH-1:WIDTH] : i_res[2*WIDTH-1:WIDTH];

  // Multiply splits the full product; divide keeps quotient in LO, remainder in HI.
  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (i_is_div) begin
      o_hi = w_rem;
      o_lo = w_quo;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = (WIDTH == MD_WIDTH) ? ITER_W : $clog2(WIDTH);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_dvsr, r_a_raw, r_hi, r_lo;
  logic               r_is_div, r_neg_main, r_neg_rem, r_b_zero, r_done;

  logic               w_accept, w_signed, w_is_div, w_busy;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_fix_hi, w_fix_lo;
  logic [WIDTH:0]     w_mul_sum, w_div_tmp, w_div_diff;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt;

  assign w_accept = (r_state == IDLE) && start;
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_a(a), .i_b(b), .i_signed(w_signed),
    .o_abs_a(w_abs_a), .o_abs_b(w_abs_b),
    .i_res(r_acc), .i_is_div(r_is_div),
    .i_neg_main(r_neg_main), .i_neg_rem(r_neg_rem),
    .o_hi(w_fix_hi), .o_lo(w_fix_lo)
  );

  // Multiply: add multiplicand into upper half when LSB set, then shift right with carry.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvsr} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: shift remainder:dividend left, subtract divisor, restore on borrow.
  assign w_div_tmp  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_tmp - {1'b0, r_dvsr};
  assign w_div_nxt  = w_div_diff[WIDTH] ? {w_div_tmp[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and busy decode.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = CALC;
      end
      CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, HI/LO commit and MTHI/MTLO writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_dvsr     <= '0;
      r_a_raw    <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b_zero   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      if (w_accept) begin
        r_cnt      <= '0;
        r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
        r_dvsr     <= w_is_div ? w_abs_b : w_abs_a;
        r_a_raw    <= a;
        r_is_div   <= w_is_div;
        r_neg_main <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_rem  <= w_signed && a[WIDTH-1];
        r_b_zero   <= (b == '0);
      end else if (r_state == IDLE) begin
        // Start takes priority; register moves only land when no op is issued.
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end else if (r_state == FIX) begin
        if (r_is_div && r_b_zero) begin
          r_hi <= r_a_raw;
          r_lo <= '1;
        end else begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = w_busy;
  assign done = r_done;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, ignore rules, reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_err = 0;
  int n_chk = 0;
  int lat, bsy, npulse;
  logic [31:0] hi_cap, lo_cap;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampling point is 1ns after each rising edge.
  task automatic wait_done(output int l, output int bz);
    l = 0; bz = 0;
    while (!done && l < 100) begin
      if (busy) bz++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     output int l, output int bz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(l, bz);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // MULTU max * max, with timing
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy);
    chk("multu_lat", lat, 33);
    chk("multu_busy", bsy, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'h0);

    run(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bsy);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bsy);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Issued in the done cycle of the previous op: back-to-back acceptance
    run(OP_DIVU, 32'd7, 32'd2, lat, bsy);
    chk("b2b_lat", lat, 33);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run(OP_DIVU, 32'd5, 32'd0, lat, bsy);
    chk("div0_lat", lat, 33);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // Start and MTHI while busy are ignored
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    mthi = 1'b0;
    #1;
    chk("calc_hold_hi", hi, 32'h0);
    chk("calc_hold_lo", lo, 32'h8000_0000);
    npulse = 0; hi_cap = '0; lo_cap = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (npulse == 0) begin hi_cap = hi; lo_cap = lo; end
        npulse++;
      end
    end
    chk("ign_pulses", npulse, 1);
    chk("ign_hi", hi_cap, 32'h0);
    chk("ign_lo", lo_cap, 32'd6);

    // MTHI + MTLO together in IDLE
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h1234);

    // Start wins over a same-cycle MTLO
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2; mtlo = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    chk("prio_lo_held", lo, 32'h1234);
    chk("prio_busy", {31'b0, busy}, 32'h1);
    wait_done(lat, bsy);
    chk("prio_lat", lat, 33);
    chk("prio_lo", lo, 32'd4);
    chk("prio_hi", hi, 32'h0);

    // Reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clk); reset = 1'b0;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    chk("abort_no_done", npulse, 0);

    run(OP_DIVU, 32'd10, 32'd3, lat, bsy);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
